bus_interval_timer: RTL and testbench

//  Programmable interval timer, bus slave at free device ID 5 on the shared system bus.
//  CPU reads/writes five registers through BusController; block raises irq on compare match.

---
 rtl/bus_interval_timer.sv | 170 +++++++++++++++++
 tb/tb_bus_interval_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interval_timer.sv
// bus_interval_timer
//   Programmable interval timer, bus slave on the shared system bus. Software programs a
//   prescaler and a compare value; the counter advances once per prescaler period and raises
//   a sticky match flag (and a level irq when enabled) when it reaches the compare value.
//
//   Register map (index taken from bus_in[3:0] in the command cycle):
//     0 CTRL     [0] enable, [1] auto_reload, [2] irq_en
//     1 PRESCALE [PRESCALE_W-1:0]
//     2 COMPARE
//     3 COUNT    (write also restarts the prescaler)
//     4 STATUS   [0] match, write 1 to clear
//     5-15       read 0, writes ignored
//
// Ports
//   clk25MHz      system clock, rising edge
//   reset         asynchronous, active-high
//   bus_slave_en  this slave is selected by the bus controller
//   bus_in        bus data (register index in command cycle, write data in the next cycle)
//   ctrl_in       bus command (CTRL_RD / CTRL_WR)
//   bus_out       read data, valid only while ctrl_out == CTRL_DONE
//   ctrl_out      CTRL_DONE for one cycle when a transaction completes, else 0
//   irq           level interrupt, match & irq_en
module bus_interval_timer #(
  parameter int unsigned         D_WIDTH    = 32,
  parameter int unsigned         C_WIDTH    = 8,
  parameter int unsigned         PRESCALE_W = 16,
  parameter logic [C_WIDTH-1:0]  CTRL_RD    = 8'h01,
  parameter logic [C_WIDTH-1:0]  CTRL_WR    = 8'h02,
  parameter logic [C_WIDTH-1:0]  CTRL_DONE  = 8'h80
) (
  input  logic               clk25MHz,
  input  logic               reset,
  input  logic               bus_slave_en,
  input  logic [D_WIDTH-1:0] bus_in,
  input  logic [C_WIDTH-1:0] ctrl_in,
  output logic [D_WIDTH-1:0] bus_out,
  output logic [C_WIDTH-1:0] ctrl_out,
  output logic               irq
);

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_t;

  state_t                  state;
  logic                    cmd_wr;
  logic [3:0]              idx;

  logic                    enable, auto_reload, irq_en, match;
  logic [PRESCALE_W-1:0]   prescale, presc_cnt;
  logic [D_WIDTH-1:0]      compare, count;

  logic                    wr_en;
  logic                    wr_ctrl, wr_presc, wr_compare, wr_count, wr_status;
  logic                    tick, match_set;
  logic [D_WIDTH-1:0]      rd_data;

  // A write takes effect at the end of the CMD cycle, provided the master is still selecting us.
  assign wr_en      = (state == StCmd) && bus_slave_en && cmd_wr;
  assign wr_ctrl    = wr_en && (idx == 4'd0);
  assign wr_presc   = wr_en && (idx == 4'd1);
  assign wr_compare = wr_en && (idx == 4'd2);
  assign wr_count   = wr_en && (idx == 4'd3);
  assign wr_status  = wr_en && (idx == 4'd4);

  assign tick      = enable && (presc_cnt == prescale);
  assign match_set = tick && (count == compare);

  assign irq = match & irq_en;

  always_comb begin
    rd_data = '0;
    case (idx)
      4'd0:    rd_data[2:0] = {irq_en, auto_reload, enable};
      4'd1:    rd_data[PRESCALE_W-1:0] = prescale;
      4'd2:    rd_data = compare;
      4'd3:    rd_data = count;
      4'd4:    rd_data[0] = match;
      default: rd_data = '0;
    endcase
  end

  // Bus slave FSM; bus_out/ctrl_out are registered and only nonzero in StResp.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      cmd_wr   <= 1'b0;
      idx      <= '0;
      bus_out  <= '0;
      ctrl_out <= '0;
    end else begin
      case (state)
        StIdle: begin
          bus_out  <= '0;
          ctrl_out <= '0;
          if (bus_slave_en && (ctrl_in == CTRL_RD || ctrl_in == CTRL_WR)) begin
            cmd_wr <= (ctrl_in == CTRL_WR);
            idx    <= bus_in[3:0];
            state  <= StCmd;
          end
        end
        StCmd: begin
          if (!bus_slave_en) begin
            state <= StIdle;
          end else begin
            ctrl_out <= CTRL_DONE;
            bus_out  <= cmd_wr ? '0 : rd_data;
            state    <= StResp;
          end
        end
        StResp: begin
          bus_out  <= '0;
          ctrl_out <= '0;
          state    <= StIdle;
        end
        default: begin
          bus_out  <= '0;
          ctrl_out <= '0;
          state    <= StIdle;
        end
      endcase
    end
  end

  // Timer datapath. Bus writes are assigned after the counting logic so they win collisions,
  // except the STATUS clear, which yields to a match set in the same cycle.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      match       <= 1'b0;
      prescale    <= '0;
      presc_cnt   <= '0;
      compare     <= '0;
      count       <= '0;
    end else begin
      if (enable) begin
        if (tick) begin
          presc_cnt <= '0;
          if (match_set) begin
            match <= 1'b1;
            count <= '0;
            if (!auto_reload) enable <= 1'b0;
          end else begin
            count <= count + {{(D_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          presc_cnt <= presc_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
      end

      if (wr_ctrl) begin
        enable      <= bus_in[0];
        auto_reload <= bus_in[1];
        irq_en      <= bus_in[2];
        if (bus_in[0] && !enable) presc_cnt <= '0;
      end
      if (wr_presc) begin
        prescale  <= bus_in[PRESCALE_W-1:0];
        presc_cnt <= '0;
      end
      if (wr_compare) compare <= bus_in;
      if (wr_count) begin
        count     <= bus_in;
        presc_cnt <= '0;
      end
      if (wr_status && bus_in[0] && !match_set) match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_interval_timer.sv
// Bench for bus_interval_timer: a behavioural register/timer model checked against the DUT on
// every falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_bus_interval_timer;

  localparam logic [7:0] RD   = 8'h01;
  localparam logic [7:0] WR   = 8'h02;
  localparam logic [7:0] DONE = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] bin = '0;
  logic [7:0]  cin = '0;
  logic [31:0] bout;
  logic [7:0]  cout;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  bus_interval_timer dut (
    .clk25MHz    (clk),
    .reset       (rst),
    .bus_slave_en(sel),
    .bus_in      (bin),
    .ctrl_in     (cin),
    .bus_out     (bout),
    .ctrl_out    (cout),
    .irq         (irq)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en = 0, m_ar = 0, m_ie = 0, m_match = 0;
  logic [15:0] m_presc = '0, m_pc = '0;
  logic [31:0] m_cmp = '0, m_cnt = '0;
  int          phase = 0;          // 2: command accepted, 1: responding, 0: free
  logic        p_wr = 0;
  logic [3:0]  p_idx = '0;
  logic [7:0]  e_ctrl = '0, n_ctrl;
  logic [31:0] e_bus = '0, n_bus, t_data;
  logic        t_wr, t_set, t_old_en;

  function automatic logic [31:0] m_read(input logic [3:0] i);
    case (i)
      4'd0:    return {29'd0, m_ie, m_ar, m_en};
      4'd1:    return {16'd0, m_presc};
      4'd2:    return m_cmp;
      4'd3:    return m_cnt;
      4'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
      m_presc = '0; m_pc = '0; m_cmp = '0; m_cnt = '0;
      phase = 0; e_ctrl = '0; e_bus = '0;
    end else begin
      n_ctrl = '0; n_bus = '0; t_wr = 0; t_data = '0;
      if (phase == 2) begin
        if (sel) begin
          n_ctrl = DONE;
          if (p_wr) begin t_wr = 1; t_data = bin; end
          else n_bus = m_read(p_idx);
          phase = 1;
        end else phase = 0;
      end else if (phase == 1) begin
        phase = 0;
      end else if (sel && (cin == RD || cin == WR)) begin
        phase = 2; p_wr = (cin == WR); p_idx = bin[3:0];
      end
      t_old_en = m_en; t_set = 0;
      if (m_en) begin
        if (m_pc == m_presc) begin
          m_pc = '0;
          if (m_cnt == m_cmp) begin
            t_set = 1; m_match = 1; m_cnt = '0;
            if (!m_ar) m_en = 0;
          end else m_cnt = m_cnt + 32'd1;
        end else m_pc = m_pc + 16'd1;
      end
      if (t_wr) begin
        case (p_idx)
          4'd0: begin
            if (t_data[0] && !t_old_en) m_pc = '0;
            m_en = t_data[0]; m_ar = t_data[1]; m_ie = t_data[2];
          end
          4'd1: begin m_presc = t_data[15:0]; m_pc = '0; end
          4'd2: m_cmp = t_data;
          4'd3: begin m_cnt = t_data; m_pc = '0; end
          4'd4: if (t_data[0] && !t_set) m_match = 0;
          default: ;
        endcase
      end
      e_ctrl = n_ctrl; e_bus = n_bus;
    end
  end

  initial forever begin
    @(negedge clk);
    check("ctrl_out", {24'd0, cout}, {24'd0, e_ctrl});
    check("bus_out", bout, e_bus);
    check("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1; sel = 1'b0; cin = '0; bin = '0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] data);
    sel = 1'b1; cin = WR; bin = {28'd0, idx};
    @(negedge clk); cin = '0; bin = data;
    @(negedge clk); sel = 1'b0; bin = '0;
    @(negedge clk);
  endtask

  task automatic bus_abort(input logic [3:0] idx, input logic [31:0] data);
    sel = 1'b1; cin = WR; bin = {28'd0, idx};
    @(negedge clk); sel = 1'b0; cin = '0; bin = data;
    @(negedge clk); bin = '0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] data,
                          output logic [7:0] early, output logic [7:0] done);
    sel = 1'b1; cin = RD; bin = {28'd0, idx};
    @(negedge clk); cin = '0; bin = '0; early = cout;
    @(negedge clk); data = bout; done = cout; sel = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic [7:0]  e, dn;

  initial begin
    // 1: reset mid-count and mid-transaction
    do_reset();
    bus_write(4'd2, 32'd10);
    bus_write(4'd3, 32'd7);
    bus_write(4'd0, 32'd7);
    begin
      int k = 0;
      while (irq !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("t1_irq_before_reset", {31'd0, irq}, 32'd1);
    end
    sel = 1'b1; cin = RD; bin = 32'd3;
    @(negedge clk); cin = '0; bin = '0;
    @(negedge clk);
    check("t1_done_before_reset", {24'd0, cout}, {24'd0, DONE});
    #2 rst = 1'b1;
    #1;
    check("t1_async_ctrl_out", {24'd0, cout}, 32'd0);
    check("t1_async_bus_out", bout, 32'd0);
    check("t1_async_irq", {31'd0, irq}, 32'd0);
    sel = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    bus_read(4'd3, d, e, dn); check("t1_count_after_reset", d, 32'd0);
    bus_read(4'd0, d, e, dn); check("t1_ctrl_after_reset", d, 32'd0);

    // 2: prescale 0, compare 3, auto reload: match every 4 cycles
    do_reset();
    bus_write(4'd1, 32'd0);
    bus_write(4'd2, 32'd3);
    bus_write(4'd0, 32'd7);
    idle(2); check("t2_irq_3_after_en", {31'd0, irq}, 32'd0);
    idle(1); check("t2_irq_4_after_en", {31'd0, irq}, 32'd1);
    check("t2_model_count", m_cnt, 32'd0);
    bus_read(4'd3, d, e, dn); check("t2_count_read", d, 32'd1);
    bus_read(4'd4, d, e, dn); check("t2_status_read", d, 32'd1);
    idle(1);
    bus_write(4'd4, 32'd1);
    check("t2_irq_cleared", {31'd0, irq}, 32'd0);
    idle(1); check("t2_irq_before_rematch", {31'd0, irq}, 32'd0);
    idle(1); check("t2_irq_rematch", {31'd0, irq}, 32'd1);

    // 3: prescale 9, compare 1, one-shot
    do_reset();
    bus_write(4'd1, 32'd9);
    bus_write(4'd2, 32'd1);
    bus_write(4'd0, 32'd5);
    idle(18); check("t3_irq_cycle19", {31'd0, irq}, 32'd0);
    idle(1);  check("t3_irq_cycle20", {31'd0, irq}, 32'd1);
    bus_read(4'd0, d, e, dn); check("t3_ctrl_disabled", d, 32'd4);
    bus_read(4'd3, d, e, dn); check("t3_count_zero", d, 32'd0);
    idle(20);
    bus_read(4'd3, d, e, dn); check("t3_count_holds", d, 32'd0);

    // 4: read latency, unmapped index, aborted write
    bus_write(4'd2, 32'hDEADBEEF);
    bus_read(4'd2, d, e, dn);
    check("t4_ctrl_in_cmd_cycle", {24'd0, e}, 32'd0);
    check("t4_done", {24'd0, dn}, 32'h80);
    check("t4_data", d, 32'hDEADBEEF);
    bus_read(4'd9, d, e, dn);
    check("t4_idx9_done", {24'd0, dn}, 32'h80);
    check("t4_idx9_data", d, 32'd0);
    bus_abort(4'd2, 32'h12345678);
    bus_read(4'd2, d, e, dn); check("t4_abort_no_write", d, 32'hDEADBEEF);

    // 5: STATUS clear colliding with a match
    do_reset();
    bus_write(4'd2, 32'd3);
    bus_write(4'd0, 32'd7);
    idle(5);
    bus_write(4'd4, 32'd1);
    check("t5_set_wins", {31'd0, irq}, 32'd1);
    bus_write(4'd0, 32'd4);
    check("t5_still_set", {31'd0, irq}, 32'd1);
    bus_write(4'd4, 32'd1);
    check("t5_cleared", {31'd0, irq}, 32'd0);
    bus_read(4'd4, d, e, dn); check("t5_status_zero", d, 32'd0);

    // 6: full-range compare and counter wrap
    do_reset();
    bus_write(4'd2, 32'hFFFFFFFF);
    bus_write(4'd3, 32'hFFFFFFFE);
    bus_write(4'd0, 32'd5);
    check("t6_no_match_tick1", {31'd0, irq}, 32'd0);
    idle(1); check("t6_match_tick2", {31'd0, irq}, 32'd1);
    bus_read(4'd3, d, e, dn); check("t6_count_zero", d, 32'd0);
    bus_read(4'd0, d, e, dn); check("t6_disabled", d, 32'd4);
    bus_write(4'd4, 32'd1);
    bus_write(4'd2, 32'd5);
    bus_write(4'd3, 32'hFFFFFFFF);
    bus_write(4'd0, 32'd5);
    check("t6_wrap_no_irq", {31'd0, irq}, 32'd0);
    check("t6_model_wrapped", m_cnt, 32'd0);
    bus_read(4'd3, d, e, dn); check("t6_count_after_wrap", d, 32'd1);
    bus_read(4'd4, d, e, dn); check("t6_status_after_wrap", d, 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
